// File: rtl/chords_pkg.sv
// Shared types and helpers for the chord voice mixer: mixer states, mix-mode
// encodings and a constant-foldable ceil(log2) used to size indices and sums.
package chords_pkg;

  typedef enum logic [1:0] {
    MIX_IDLE    = 2'd0,
    MIX_COLLECT = 2'd1,
    MIX_SUM     = 2'd2
  } mix_state_e;

  localparam int MIX_SAT_SCALE = 0;
  localparam int MIX_SAT_CLAMP = 1;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/note_player.sv
// Single voice: plays a note for a number of beats and answers each sample
// request one cycle later. Output level is tied to the note index.
module note_player (
  input  logic        clk,
  input  logic        reset,
  input  logic        play_enable,
  input  logic        load_new_note,
  input  logic [5:0]  note_to_load,
  input  logic [5:0]  duration_to_load,
  input  logic        beat,
  input  logic        generate_next_sample,
  output logic        done_with_note,
  output logic [15:0] sample_out,
  output logic        new_sample_ready
);

  logic       playing;
  logic [5:0] note_q;
  logic [5:0] beats_left;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      playing          <= 1'b0;
      note_q           <= '0;
      beats_left       <= '0;
      sample_out       <= '0;
      new_sample_ready <= 1'b0;
    end else begin
      new_sample_ready <= generate_next_sample;
      // a paused or idle voice still answers, with silence, so the mixer never stalls
      if (generate_next_sample)
        sample_out <= (playing && play_enable) ? {note_q, 10'b0} : 16'h0000;
      if (load_new_note) begin
        playing    <= 1'b1;
        note_q     <= note_to_load;
        beats_left <= duration_to_load;
      end else if (playing && play_enable && beat) begin
        if (beats_left <= 6'd1) playing    <= 1'b0;
        else                    beats_left <= beats_left - 6'd1;
      end
    end
  end

  assign done_with_note = ~playing;

endmodule

// File: rtl/voice_allocator.sv
// Routes each new_note to the lowest free voice, or steals the oldest one,
// and tracks reservations so back-to-back notes land on distinct voices.
module voice_allocator
  import chords_pkg::*;
#(
  parameter int NUM_VOICES = 3,
  parameter int STEAL_EN   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  new_note,
  input  logic [5:0]            note_to_load,
  input  logic [5:0]            duration_to_load,
  input  logic [NUM_VOICES-1:0] done_with_note,
  output logic [NUM_VOICES-1:0] load_new_note,
  output logic [5:0]            note_q,
  output logic [5:0]            dur_q,
  output logic [NUM_VOICES-1:0] reserved,
  output logic                  player_available,
  output logic [7:0]            notes_dropped
);

  localparam int IW = clog2(NUM_VOICES);
  localparam int AW = IW + 1;

  logic [NUM_VOICES-1:0] free;
  logic                  have_free;
  logic [IW-1:0]         free_idx;
  logic [IW-1:0]         oldest_idx;
  logic [IW-1:0]         alloc_idx;
  logic                  do_alloc;
  logic [AW-1:0]         alloc_cnt;
  logic [AW-1:0]         stamp [NUM_VOICES];

  assign free = done_with_note & ~reserved;

  always_comb begin
    have_free = 1'b0;
    free_idx  = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (free[i]) begin
        have_free = 1'b1;
        free_idx  = IW'(i);
      end
    end
  end

  // age is the modular distance from a voice's stamp to the running counter
  always_comb begin
    logic [AW-1:0] age;
    logic [AW-1:0] best_age;
    age        = '0;
    best_age   = '0;
    oldest_idx = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      age = alloc_cnt - stamp[i];
      if (age > best_age) begin
        best_age   = age;
        oldest_idx = IW'(i);
      end
    end
  end

  assign alloc_idx        = have_free ? free_idx : oldest_idx;
  assign do_alloc         = new_note && (have_free || (STEAL_EN != 0));
  assign player_available = have_free || (STEAL_EN != 0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_new_note <= '0;
      note_q        <= '0;
      dur_q         <= '0;
      reserved      <= '0;
      notes_dropped <= '0;
      alloc_cnt     <= '0;
      for (int i = 0; i < NUM_VOICES; i++) stamp[i] <= '0;
    end else begin
      load_new_note <= '0;
      for (int i = 0; i < NUM_VOICES; i++)
        if (!done_with_note[i]) reserved[i] <= 1'b0;
      if (do_alloc) begin
        note_q                   <= note_to_load;
        dur_q                    <= duration_to_load;
        load_new_note[alloc_idx] <= 1'b1;
        reserved[alloc_idx]      <= 1'b1;
        stamp[alloc_idx]         <= alloc_cnt;
        alloc_cnt                <= alloc_cnt + 1'b1;
      end else if (new_note && notes_dropped != 8'hFF) begin
        notes_dropped <= notes_dropped + 8'd1;
      end
    end
  end

endmodule

// File: rtl/chord_voice_mixer.sv
// Polyphonic voice pool: allocates notes across NUM_VOICES note_players and
// mixes their samples into one 16-bit signed output once every voice reports.
module chord_voice_mixer
  import chords_pkg::*;
#(
  parameter int NUM_VOICES = 3,
  parameter int STEAL_EN   = 0,
  parameter int MIX_SAT    = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  new_note,
  input  logic [5:0]            note_to_load,
  input  logic [5:0]            duration_to_load,
  input  logic                  play_enable,
  input  logic                  beat,
  input  logic                  generate_next_sample,
  output logic                  player_available,
  output logic [15:0]           sample_out_player,
  output logic                  new_sample_ready_player,
  output logic [NUM_VOICES-1:0] voice_busy,
  output logic [7:0]            notes_dropped
);

  localparam int IW = clog2(NUM_VOICES);
  localparam int SW = 16 + IW;
  localparam logic signed [SW-1:0] POS_MAX = SW'(32767);
  localparam logic signed [SW-1:0] NEG_MIN = SW'(-32768);

  logic [NUM_VOICES-1:0] load_new_note;
  logic [NUM_VOICES-1:0] done_with_note;
  logic [NUM_VOICES-1:0] new_sample_ready;
  logic [NUM_VOICES-1:0] reserved;
  logic [NUM_VOICES-1:0] idle_voice;
  logic [NUM_VOICES-1:0] ready_mask;
  logic [NUM_VOICES-1:0] mask_next;
  logic [5:0]            note_q;
  logic [5:0]            dur_q;
  logic [15:0]           voice_sample [NUM_VOICES];
  logic [15:0]           latched      [NUM_VOICES];
  logic signed [SW-1:0]  sum;
  logic [15:0]           mixed;
  mix_state_e            state;

  voice_allocator #(
    .NUM_VOICES (NUM_VOICES),
    .STEAL_EN   (STEAL_EN)
  ) u_alloc (
    .clk              (clk),
    .reset            (reset),
    .new_note         (new_note),
    .note_to_load     (note_to_load),
    .duration_to_load (duration_to_load),
    .done_with_note   (done_with_note),
    .load_new_note    (load_new_note),
    .note_q           (note_q),
    .dur_q            (dur_q),
    .reserved         (reserved),
    .player_available (player_available),
    .notes_dropped    (notes_dropped)
  );

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
    note_player u_voice (
      .clk                  (clk),
      .reset                (reset),
      .play_enable          (play_enable),
      .load_new_note        (load_new_note[g]),
      .note_to_load         (note_q),
      .duration_to_load     (dur_q),
      .beat                 (beat),
      .generate_next_sample (generate_next_sample),
      .done_with_note       (done_with_note[g]),
      .sample_out           (voice_sample[g]),
      .new_sample_ready     (new_sample_ready[g])
    );
  end

  assign voice_busy = reserved | ~done_with_note;
  assign idle_voice = done_with_note & ~reserved;
  assign mask_next  = ready_mask | new_sample_ready | idle_voice;

  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_VOICES; i++)
      sum = sum + {{IW{latched[i][15]}}, latched[i]};
    if (MIX_SAT == MIX_SAT_CLAMP) begin
      if (sum > POS_MAX)      mixed = 16'h7FFF;
      else if (sum < NEG_MIN) mixed = 16'h8000;
      else                    mixed = 16'(sum);
    end else begin
      mixed = 16'(sum >>> IW);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                   <= MIX_IDLE;
      ready_mask              <= '0;
      sample_out_player       <= '0;
      new_sample_ready_player <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) latched[i] <= '0;
    end else begin
      new_sample_ready_player <= 1'b0;
      case (state)
        MIX_IDLE: begin
          if (generate_next_sample) begin
            ready_mask <= '0;
            state      <= MIX_COLLECT;
          end
        end
        MIX_COLLECT: begin
          if (generate_next_sample) begin
            ready_mask <= '0;
          end else begin
            ready_mask <= mask_next;
            // only the first report per request is latched; idle voices contribute silence
            for (int i = 0; i < NUM_VOICES; i++) begin
              if (!ready_mask[i]) begin
                if (new_sample_ready[i]) latched[i] <= voice_sample[i];
                else if (idle_voice[i])  latched[i] <= '0;
              end
            end
            if (&mask_next) state <= MIX_SUM;
          end
        end
        MIX_SUM: begin
          if (generate_next_sample) begin
            ready_mask <= '0;
            state      <= MIX_COLLECT;
          end else begin
            sample_out_player       <= mixed;
            new_sample_ready_player <= 1'b1;
            state                   <= MIX_IDLE;
          end
        end
        default: state <= MIX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chord_voice_mixer.sv
// Directed bench: one drop-mode/scaled mixer and one steal-mode/saturating
// mixer driven by the same stimulus, checked against hand-computed values.
module tb_chord_voice_mixer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        new_note = 1'b0;
  logic [5:0]  note_to_load = '0;
  logic [5:0]  duration_to_load = '0;
  logic        play_enable = 1'b1;
  logic        beat = 1'b0;
  logic        generate_next_sample = 1'b0;

  logic        avail_a, avail_b, rdy_a, rdy_b;
  logic [15:0] out_a, out_b;
  logic [2:0]  busy_a, busy_b;
  logic [7:0]  dropped_a, dropped_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  chord_voice_mixer #(.NUM_VOICES(3), .STEAL_EN(0), .MIX_SAT(0)) dut_a (
    .clk(clk), .reset(reset), .new_note(new_note), .note_to_load(note_to_load),
    .duration_to_load(duration_to_load), .play_enable(play_enable), .beat(beat),
    .generate_next_sample(generate_next_sample), .player_available(avail_a),
    .sample_out_player(out_a), .new_sample_ready_player(rdy_a),
    .voice_busy(busy_a), .notes_dropped(dropped_a));

  chord_voice_mixer #(.NUM_VOICES(3), .STEAL_EN(1), .MIX_SAT(1)) dut_b (
    .clk(clk), .reset(reset), .new_note(new_note), .note_to_load(note_to_load),
    .duration_to_load(duration_to_load), .play_enable(play_enable), .beat(beat),
    .generate_next_sample(generate_next_sample), .player_available(avail_b),
    .sample_out_player(out_b), .new_sample_ready_player(rdy_b),
    .voice_busy(busy_b), .notes_dropped(dropped_b));

  typedef struct {
    logic [5:0] note;
    logic [2:0] exp_busy;
    logic       exp_avail_a;
  } alloc_vec_t;

  typedef struct {
    logic [5:0]  n0, n1, n2;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
  } mix_vec_t;

  alloc_vec_t alloc_tbl [3];
  mix_vec_t   mix_tbl [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic load3(input logic [5:0] n0, n1, n2, input logic [5:0] dur);
    duration_to_load = dur;
    new_note = 1'b1;
    note_to_load = n0;
    @(negedge clk);
    note_to_load = n1;
    @(negedge clk);
    note_to_load = n2;
    @(negedge clk);
    new_note = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // raises the request for 'hold' cycles and watches a bounded window for pulses
  task automatic get_sample(input string name, input int hold, input int exp_lat,
                            input logic [15:0] exp_a, input logic [15:0] exp_b);
    int n_a, n_b, lat_a, lat_b;
    logic [15:0] got_a, got_b;
    n_a = 0; n_b = 0; lat_a = 0; lat_b = 0; got_a = '0; got_b = '0;
    generate_next_sample = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == hold) generate_next_sample = 1'b0;
      if (rdy_a) begin n_a++; if (lat_a == 0) begin lat_a = k; got_a = out_a; end end
      if (rdy_b) begin n_b++; if (lat_b == 0) begin lat_b = k; got_b = out_b; end end
    end
    check({name, " pulses_a"}, n_a, 1);
    check({name, " pulses_b"}, n_b, 1);
    check({name, " latency_a"}, lat_a, exp_lat);
    check({name, " latency_b"}, lat_b, exp_lat);
    check({name, " sample_a"}, got_a, exp_a);
    check({name, " sample_b"}, got_b, exp_b);
  endtask

  initial begin
    alloc_tbl[0] = '{note: 6'd10, exp_busy: 3'b001, exp_avail_a: 1'b1};
    alloc_tbl[1] = '{note: 6'd20, exp_busy: 3'b011, exp_avail_a: 1'b1};
    alloc_tbl[2] = '{note: 6'd30, exp_busy: 3'b111, exp_avail_a: 1'b0};

    mix_tbl[0] = '{n0: 6'd16, n1: 6'd16, n2: 6'd16, exp_a: 16'h3000, exp_b: 16'h7FFF};
    mix_tbl[1] = '{n0: 6'd32, n1: 6'd32, n2: 6'd32, exp_a: 16'hA000, exp_b: 16'h8000};
    mix_tbl[2] = '{n0: 6'd10, n1: 6'd20, n2: 6'd30, exp_a: 16'h3C00, exp_b: 16'h7FFF};
    mix_tbl[3] = '{n0: 6'd1,  n1: 6'd2,  n2: 6'd3,  exp_a: 16'h0600, exp_b: 16'h1800};
    mix_tbl[4] = '{n0: 6'd48, n1: 6'd1,  n2: 6'd0,  exp_a: 16'hF100, exp_b: 16'hC400};
    mix_tbl[5] = '{n0: 6'd63, n1: 6'd63, n2: 6'd0,  exp_a: 16'hFE00, exp_b: 16'hF800};

    repeat (2) @(negedge clk);
    check("reset out_a", out_a, 16'h0000);
    check("reset out_b", out_b, 16'h0000);
    check("reset rdy", {rdy_a, rdy_b}, 2'b00);
    check("reset busy", {busy_a, busy_b}, 6'b000000);
    check("reset dropped", {dropped_a, dropped_b}, 16'h0000);
    check("reset avail", {avail_a, avail_b}, 2'b11);
    reset = 1'b0;
    @(negedge clk);

    // three notes on consecutive cycles land on voices 0, 1, 2
    duration_to_load = 6'd5;
    for (int i = 0; i < 3; i++) begin
      new_note = 1'b1;
      note_to_load = alloc_tbl[i].note;
      @(negedge clk);
      check($sformatf("alloc%0d busy_a", i), busy_a, alloc_tbl[i].exp_busy);
      check($sformatf("alloc%0d busy_b", i), busy_b, alloc_tbl[i].exp_busy);
      check($sformatf("alloc%0d avail_a", i), avail_a, alloc_tbl[i].exp_avail_a);
      check($sformatf("alloc%0d avail_b", i), avail_b, 1'b1);
    end
    new_note = 1'b0;
    repeat (3) @(negedge clk);
    check("settled busy_a", busy_a, 3'b111);
    check("settled avail_a", avail_a, 1'b0);

    // fourth note: dropped by A, steals voice 0 in B
    new_note = 1'b1;
    note_to_load = 6'd40;
    @(negedge clk);
    new_note = 1'b0;
    repeat (3) @(negedge clk);
    check("drop dropped_a", dropped_a, 8'd1);
    check("steal dropped_b", dropped_b, 8'd0);
    check("steal busy_b", busy_b, 3'b111);
    get_sample("after_steal", 1, 3, 16'h3C00, 16'h6800);

    // a second request while collecting restarts the collection
    get_sample("restart", 2, 4, 16'h3C00, 16'h6800);

    play_enable = 1'b0;
    get_sample("paused", 1, 3, 16'h0000, 16'h0000);
    play_enable = 1'b1;

    new_note = 1'b1;
    repeat (260) @(negedge clk);
    new_note = 1'b0;
    @(negedge clk);
    check("drop saturate_a", dropped_a, 8'd255);
    check("drop saturate_b", dropped_b, 8'd0);

    // notes expire after their beat count
    do_reset();
    load3(6'd1, 6'd2, 6'd3, 6'd2);
    check("dur busy_a start", busy_a, 3'b111);
    beat = 1'b1; @(negedge clk); beat = 1'b0; @(negedge clk);
    check("dur busy_a one_beat", busy_a, 3'b111);
    beat = 1'b1; @(negedge clk); beat = 1'b0; @(negedge clk);
    check("dur busy_a done", busy_a, 3'b000);
    check("dur busy_b done", busy_b, 3'b000);
    check("dur avail_a", avail_a, 1'b1);

    // reset in the middle of a collection
    do_reset();
    load3(6'd16, 6'd16, 6'd16, 6'd5);
    get_sample("pre_reset", 1, 3, 16'h3000, 16'h7FFF);
    generate_next_sample = 1'b1;
    @(negedge clk);
    generate_next_sample = 1'b0;
    reset = 1'b1;
    #1;
    check("midreset out_a", out_a, 16'h0000);
    check("midreset out_b", out_b, 16'h0000);
    begin
      int pulses;
      pulses = 0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if (rdy_a || rdy_b) pulses++;
      end
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if (rdy_a || rdy_b) pulses++;
      end
      check("midreset no_pulse", pulses, 0);
    end
    get_sample("post_reset", 1, 3, 16'h0000, 16'h0000);

    for (int r = 0; r < 6; r++) begin
      do_reset();
      load3(mix_tbl[r].n0, mix_tbl[r].n1, mix_tbl[r].n2, 6'd5);
      get_sample($sformatf("mix%0d", r), 1, 3, mix_tbl[r].exp_a, mix_tbl[r].exp_b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
